qmem_sram16_ctrl: RTL and testbench



---
 rtl/qmem_sram16_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_qmem_sram16_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmem_sram16_ctrl.sv
// QMEM 16-bit slave driving an external asynchronous 16-bit SRAM.
// Each QMEM access becomes one SRAM word cycle with programmable read/write
// wait states. All outputs, including every SRAM strobe, come straight from
// flops, so the pads never see a combinational glitch.
module qmem_sram16_ctrl #(
  parameter int QAW   = 22,
  parameter int QSW   = 2,
  parameter int QDW   = 16,
  parameter int SAW   = 20,
  parameter int RD_WS = 2,
  parameter int WR_WS = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [QAW-1:0] adr,
  input  logic           cs,
  input  logic           we,
  input  logic [QSW-1:0] sel,
  input  logic [QDW-1:0] dat_w,
  output logic [QDW-1:0] dat_r,
  output logic           ack,
  output logic           err,
  output logic [SAW-1:0] sram_adr,
  output logic           sram_ce_n,
  output logic           sram_oe_n,
  output logic           sram_we_n,
  output logic           sram_ub_n,
  output logic           sram_lb_n,
  output logic [15:0]    sram_dat_w,
  output logic           sram_dat_oe,
  input  logic [15:0]    sram_dat_r
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    DONE
  } state_t;

  localparam logic [3:0] RD_CNT = 4'(RD_WS);
  localparam logic [3:0] WR_CNT = 4'(WR_WS);

  state_t         state, state_d;
  logic [3:0]     wcnt, wcnt_d;
  logic           ack_d, err_d;
  logic [QDW-1:0] dat_r_d;
  logic [SAW-1:0] sram_adr_d;
  logic           ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;
  logic [15:0]    sram_dat_w_d;
  logic           dat_oe_d;
  logic           out_of_range;

  // Any address bit above the SRAM's byte range makes the access invalid.
  assign out_of_range = (adr >> (SAW + 1)) != '0;

  // State, wait counter and every output register.
  // NOTE: asynchronous reset forces the strobes inactive at once, even mid
  // write pulse; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wcnt        <= '0;
      ack         <= 1'b0;
      err         <= 1'b0;
      dat_r       <= '0;
      sram_adr    <= '0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
      sram_dat_w  <= '0;
      sram_dat_oe <= 1'b0;
    end else begin
      state       <= state_d;
      wcnt        <= wcnt_d;
      ack         <= ack_d;
      err         <= err_d;
      dat_r       <= dat_r_d;
      sram_adr    <= sram_adr_d;
      sram_ce_n   <= ce_n_d;
      sram_oe_n   <= oe_n_d;
      sram_we_n   <= we_n_d;
      sram_ub_n   <= ub_n_d;
      sram_lb_n   <= lb_n_d;
      sram_dat_w  <= sram_dat_w_d;
      sram_dat_oe <= dat_oe_d;
    end
  end

  // Next-state and next-output decode for the SRAM access sequence.
  always_comb begin
    // NOTE: every target gets a default before the case so no path through
    // the decode can leave a variable unassigned and infer a latch.
    state_d      = state;
    wcnt_d       = wcnt;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    dat_r_d      = dat_r;
    sram_adr_d   = sram_adr;
    ce_n_d       = sram_ce_n;
    oe_n_d       = sram_oe_n;
    we_n_d       = sram_we_n;
    ub_n_d       = sram_ub_n;
    lb_n_d       = sram_lb_n;
    sram_dat_w_d = sram_dat_w;
    dat_oe_d     = sram_dat_oe;

    case (state)
      IDLE: begin
        if (cs) begin
          sram_adr_d = adr[SAW:1];
          if (out_of_range) begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            state_d = DONE;
          end else if (sel == '0) begin
            ack_d   = 1'b1;
            state_d = DONE;
          end else if (we) begin
            ce_n_d       = 1'b0;
            ub_n_d       = ~sel[1];
            lb_n_d       = ~sel[0];
            sram_dat_w_d = 16'(dat_w);
            dat_oe_d     = 1'b1;
            state_d      = WR_SETUP;
          end else begin
            ce_n_d  = 1'b0;
            oe_n_d  = 1'b0;
            ub_n_d  = ~sel[1];
            lb_n_d  = ~sel[0];
            wcnt_d  = RD_CNT;
            state_d = RD;
          end
        end
      end

      RD: begin
        if (wcnt == '0) begin
          // Sample the SRAM and release all strobes on the same edge.
          dat_r_d = QDW'(sram_dat_r);
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          ub_n_d  = 1'b1;
          lb_n_d  = 1'b1;
          ack_d   = 1'b1;
          state_d = DONE;
        end else begin
          wcnt_d = wcnt - 4'd1;
        end
      end

      WR_SETUP: begin
        we_n_d  = 1'b0;
        wcnt_d  = WR_CNT;
        state_d = WR_PULSE;
      end

      WR_PULSE: begin
        if (wcnt == '0) begin
          // End the pulse but keep ce_n, address and data for one hold cycle.
          we_n_d  = 1'b1;
          ack_d   = 1'b1;
          state_d = DONE;
        end else begin
          wcnt_d = wcnt - 4'd1;
        end
      end

      DONE: begin
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        ub_n_d   = 1'b1;
        lb_n_d   = 1'b1;
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        ub_n_d   = 1'b1;
        lb_n_d   = 1'b1;
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_qmem_sram16_ctrl.sv
// Scoreboard bench for qmem_sram16_ctrl: a driver issues QMEM accesses and
// pushes the expected response computed from a word-array reference model;
// a monitor pops and compares on every ack; a pin checker compares the SRAM
// strobes each cycle against the access timeline.
module tb_qmem_sram16_ctrl;

  localparam int QAW    = 22;
  localparam int QSW    = 2;
  localparam int QDW    = 16;
  localparam int SAW    = 20;
  localparam int RD_WS  = 2;
  localparam int WR_WS  = 1;
  localparam int RD_LAT = RD_WS + 2;
  localparam int WR_LAT = WR_WS + 3;

  typedef enum logic [1:0] {K_NUL, K_RD, K_WR} kind_t;
  typedef struct {
    kind_t       kind;
    int          ack_cyc;
    logic        err;
    logic [15:0] data;
    logic [1:0]  sel;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [QAW-1:0] adr;
  logic           cs, we;
  logic [QSW-1:0] sel;
  logic [QDW-1:0] dat_w, dat_r;
  logic           ack, err;
  logic [SAW-1:0] sram_adr;
  logic           sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [15:0]    sram_dat_w, sram_dat_r;
  logic           sram_dat_oe;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t        sb_q[$];
  logic [15:0] ref_mem[int];
  logic [15:0] dev_mem[int];

  logic        cur_valid = 1'b0;
  kind_t       cur_kind  = K_NUL;
  logic [1:0]  cur_sel   = 2'b00;
  int          cur_word  = 0;
  logic [15:0] cur_data  = '0;
  int          cur_issue = 0;
  logic        scramble  = 1'b0;
  int          oe_hi_cnt = 0;
  logic        prev_doe  = 1'b0;

  qmem_sram16_ctrl #(
    .QAW(QAW), .QSW(QSW), .QDW(QDW), .SAW(SAW), .RD_WS(RD_WS), .WR_WS(WR_WS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adr(adr), .cs(cs), .we(we), .sel(sel),
    .dat_w(dat_w), .dat_r(dat_r), .ack(ack), .err(err),
    .sram_adr(sram_adr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
    .sram_dat_w(sram_dat_w), .sram_dat_oe(sram_dat_oe), .sram_dat_r(sram_dat_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Power-on contents shared by the device and the reference memory.
  function automatic logic [15:0] init_pat(input int w);
    return 16'(w * 40503 + 4951);
  endfunction

  function automatic logic [15:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : init_pat(w);
  endfunction

  function automatic logic [15:0] dev_rd(input int w);
    return dev_mem.exists(w) ? dev_mem[w] : init_pat(w);
  endfunction

  // Asynchronous SRAM device: drives data while selected, junk otherwise.
  always @(negedge clk)
    sram_dat_r <= (sram_ce_n === 1'b0 && sram_oe_n === 1'b0) ? dev_rd(int'(sram_adr))
                                                             : 16'($urandom);

  // The device commits a write on the rising edge of we_n.
  always @(posedge sram_we_n) begin
    int          w;
    logic [15:0] v;
    if (rst_n === 1'b1 && sram_ce_n === 1'b0 && sram_dat_oe === 1'b1) begin
      w = int'(sram_adr);
      v = dev_rd(w);
      if (sram_ub_n === 1'b0) v[15:8] = sram_dat_w[15:8];
      if (sram_lb_n === 1'b0) v[7:0]  = sram_dat_w[7:0];
      dev_mem[w] = v;
    end
  end

  // Expected {ce_n, oe_n, we_n, ub_n, lb_n, dat_oe} and care-mask in cycle r.
  function automatic logic [11:0] pin_plan(input kind_t k, input logic [1:0] s, input int r);
    logic [5:0] e;
    logic [5:0] m;
    e = 6'b111110;
    m = 6'b111111;
    if (k == K_RD && r >= 1 && r <= RD_WS + 1)      e = {2'b00, 1'b1, ~s[1], ~s[0], 1'b0};
    else if (k == K_WR && r == 1)                   e = {2'b01, 1'b1, ~s[1], ~s[0], 1'b1};
    else if (k == K_WR && r >= 2 && r <= WR_WS + 2) e = {2'b01, 1'b0, ~s[1], ~s[0], 1'b1};
    else if (k == K_WR && r == WR_LAT) begin
      e = 6'b011111;
      m = 6'b111001;
    end
    return {m, e};
  endfunction

  // Pin checker: strobes, address, write data and read/write turnaround.
  always @(negedge clk) begin
    logic [11:0] plan;
    logic [5:0]  pins;
    if (rst_n === 1'b1) begin
      plan = cur_valid ? pin_plan(cur_kind, cur_sel, cyc - cur_issue) : {6'h3f, 6'b111110};
      pins = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dat_oe};
      check("strobes", pins & plan[11:6], plan[5:0] & plan[11:6]);
      if (cur_valid && sram_ce_n === 1'b0) check("sram_adr", sram_adr, cur_word);
      if (cur_valid && sram_dat_oe === 1'b1) check("sram_dat_w", sram_dat_w, cur_data);
      if (sram_dat_oe === 1'b1 && prev_doe === 1'b0)
        check("oe_turnaround", 32'(oe_hi_cnt >= 2), 1);
      oe_hi_cnt = (sram_oe_n === 1'b1) ? oe_hi_cnt + 1 : 0;
      prev_doe  = sram_dat_oe;
    end
  end

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] m;
    if (rst_n === 1'b1) begin
      if (err === 1'b1) check("err_with_ack", ack, 1);
      if (ack === 1'b1) begin
        check("ack_expected", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          m = {{8{e.sel[1]}}, {8{e.sel[0]}}};
          check("ack_cycle", cyc, e.ack_cyc);
          check("err", err, e.err);
          if (e.kind == K_RD) check("rd_data", dat_r & m, e.data & m);
        end
      end
    end
  end

  // One QMEM access; returns on the negedge of its ack cycle with cs still high.
  task automatic access(input logic w, input logic [QAW-1:0] a, input logic [1:0] s,
                        input logic [15:0] d);
    exp_t        e;
    int          word;
    int          n;
    logic        got;
    logic [15:0] v;
    @(posedge clk);
    #1;
    cs = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    word   = int'(a) / 2;
    e.sel  = s;
    e.err  = (int'(a) >= (1 << (SAW + 1)));
    e.data = '0;
    if (e.err || s == 2'b00) begin
      e.kind    = K_NUL;
      e.ack_cyc = cyc + 1;
    end else if (!w) begin
      e.kind    = K_RD;
      e.ack_cyc = cyc + RD_LAT;
      e.data    = ref_rd(word);
    end else begin
      e.kind    = K_WR;
      e.ack_cyc = cyc + WR_LAT;
      v = ref_rd(word);
      if (s[1]) v[15:8] = d[15:8];
      if (s[0]) v[7:0]  = d[7:0];
      ref_mem[word] = v;
    end
    sb_q.push_back(e);
    cur_kind = e.kind; cur_sel = s; cur_word = word; cur_data = d;
    cur_issue = cyc; cur_valid = 1'b1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack === 1'b1) got = 1'b1;
      else if (scramble && n > 1) begin
        adr = QAW'($urandom); we = 1'($urandom); sel = 2'($urandom); dat_w = 16'($urandom);
      end
    end
    check("ack_seen", got, 1);
    if (!got) begin
      sb_q.delete();
      cur_valid = 1'b0;
      cs = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    cs = 1'b0;
    cur_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input int w, input logic [15:0] v);
    ref_mem[w] = v;
    dev_mem[w] = v;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] tmp;
    int          n;
    logic        w;
    logic        oor;
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_w = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_dat_r", dat_r, 0);
    check("rst_sram_adr", sram_adr, 0);
    check("rst_sram_dat_w", sram_dat_w, 0);
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dat_oe},
          6'b111110);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full-word read with the configured read wait states.
    preload(32'h92, 16'hBEEF);
    access(1'b0, 22'h000124, 2'b11, 16'h0000);
    check("read_beef", dat_r, 16'hBEEF);
    idle(2);

    // Upper-byte write, then confirm the lower byte survived.
    access(1'b1, 22'h000010, 2'b10, 16'hA55A);
    idle(2);
    tmp = init_pat(8);
    check("wr_word8", dev_rd(8), {8'hA5, tmp[7:0]});
    access(1'b0, 22'h000010, 2'b11, 16'h0000);
    idle(2);

    // Out-of-range and null accesses touch no strobe.
    access(1'b0, 22'h200000, 2'b11, 16'h0000);
    idle(2);
    access(1'b1, 22'h000020, 2'b00, 16'hFFFF);
    idle(2);

    // Back-to-back read then write with cs held, then readback.
    access(1'b0, 22'h000000, 2'b11, 16'h0000);
    access(1'b1, 22'h000002, 2'b11, 16'h1234);
    access(1'b0, 22'h000002, 2'b11, 16'h0000);
    check("b2b_readback", dat_r, 16'h1234);
    idle(2);

    // Reset in the middle of a write pulse.
    @(posedge clk);
    #1;
    cs = 1'b1; we = 1'b1; adr = 22'h000040; sel = 2'b11; dat_w = 16'hCAFE;
    cur_kind = K_WR; cur_sel = 2'b11; cur_word = 32'h20; cur_data = 16'hCAFE;
    cur_issue = cyc; cur_valid = 1'b1;
    n = 0;
    while (sram_we_n !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_we_low", sram_we_n, 0);
    #2;
    rst_n = 1'b0;
    cur_valid = 1'b0;
    #1;
    check("rst_async_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dat_oe}, 4'b1110);
    cs = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_ack", ack, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, ack},
          6'b111110);
    access(1'b0, 22'h000040, 2'b11, 16'h0000);
    idle(2);

    // Randomized traffic with inputs scrambled while an access is in flight.
    scramble = 1'b1;
    repeat (300) begin
      w   = 1'($urandom);
      oor = ($urandom_range(0, 9) == 0);
      access(w, {oor, 20'($urandom_range(0, 31)), 1'($urandom)}, 2'($urandom), 16'($urandom));
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    scramble = 1'b0;
    idle(4);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
